// File: rtl/lgn_class_scorer.sv
// Time-multiplexed per-class popcount and sequential argmax for the LGN classifier output.
// One pass takes STEPS accumulation cycles followed by CLASSES compare cycles.
`timescale 1ns/1ps
module lgn_class_scorer #(
  parameter int unsigned CLASSES = 10,
  parameter int unsigned GROUP   = 400,
  parameter int unsigned CHUNK   = 40,
  localparam int unsigned STEPS  = GROUP / CHUNK,
  localparam int unsigned SW     = $clog2(GROUP + 1),
  localparam int unsigned CW     = $clog2(CLASSES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [CLASSES*GROUP-1:0]   y,
  input  logic [CW-1:0]              class_sel,
  output logic                       busy,
  output logic                       done,
  output logic [CW-1:0]              best_class,
  output logic [SW-1:0]              best_score,
  output logic [SW-1:0]              score_out
);

  localparam int unsigned STW = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_ARGMAX = 2'd2;

  if (GROUP % CHUNK != 0) begin : g_bad_chunk
    $error("lgn_class_scorer: GROUP must be a multiple of CHUNK");
  end

  logic [1:0]    state_q, state_d;
  logic [STW-1:0] step_q, step_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [SW-1:0] acc_q [CLASSES];
  logic [SW-1:0] acc_d [CLASSES];
  logic [CW-1:0] run_class_q, run_class_d;
  logic [SW-1:0] run_score_q, run_score_d;
  logic [CW-1:0] best_class_q, best_class_d;
  logic [SW-1:0] best_score_q, best_score_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  function automatic logic [SW-1:0] popcnt(input logic [CHUNK-1:0] v);
    logic [SW-1:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum = sum + SW'(v[i]);
    end
    return sum;
  endfunction

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    run_class_d  = run_class_q;
    run_score_d  = run_score_q;
    best_class_d = best_class_q;
    best_score_d = best_score_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int unsigned c = 0; c < CLASSES; c++) begin
            acc_d[c] = '0;
          end
          step_d  = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        for (int unsigned c = 0; c < CLASSES; c++) begin
          acc_d[c] = acc_q[c] + popcnt(y[c*GROUP + 32'(step_q)*CHUNK +: CHUNK]);
        end
        if (step_q == STW'(STEPS - 1)) begin
          idx_d   = '0;
          state_d = S_ARGMAX;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_ARGMAX: begin
        // Strict compare keeps the lowest index on ties
        if (idx_q == '0 || acc_q[idx_q] > run_score_q) begin
          run_class_d = idx_q;
          run_score_d = acc_q[idx_q];
        end
        if (idx_q == CW'(CLASSES - 1)) begin
          best_class_d = run_class_d;
          best_score_d = run_score_d;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      idx_q        <= '0;
      run_class_q  <= '0;
      run_score_q  <= '0;
      best_class_q <= '0;
      best_score_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int unsigned c = 0; c < CLASSES; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      idx_q        <= idx_d;
      run_class_q  <= run_class_d;
      run_score_q  <= run_score_d;
      best_class_q <= best_class_d;
      best_score_q <= best_score_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      for (int unsigned c = 0; c < CLASSES; c++) begin
        acc_q[c] <= acc_d[c];
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign best_class = best_class_q;
  assign best_score = best_score_q;
  assign score_out  = (32'(class_sel) < 32'(CLASSES)) ? acc_q[class_sel] : '0;

endmodule

// File: doc/lgn_class_scorer.md
# lgn_class_scorer

Sequential, parametrised class scorer for the logic-gate-network classifier. Takes the flat LGN output vector, popcounts it per class over several cycles using `CHUNK` bits per class per cycle, and selects the winning class with a sequential argmax. It sits between the LGN core and the chip output pins. It replaces the single-cycle whole-vector bit sum with a time-multiplexed, per-class, handshaked result.

## Interface
Parameters:
- `CLASSES`, 10: number of classes; the LGN output is split into `CLASSES` equal contiguous groups.
- `GROUP`, 400: LGN output bits per class; class c owns `y[c*GROUP +: GROUP]`.
- `CHUNK`, 40: bits per class popcounted per cycle. `GROUP % CHUNK` must be 0, otherwise elaboration fails.
- Derived: `STEPS = GROUP/CHUNK`; `SW = $clog2(GROUP+1)` (score width); `CW = $clog2(CLASSES)` (class index width).

Ports:
- `clk`, in, 1: clock, rising edge. One clock domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a scoring pass. Sampled only in IDLE.
- `y`, in, `CLASSES*GROUP`: LGN outputs. Must be held stable from the `start` edge until `done`.
- `class_sel`, in, `CW`: selects the accumulator shown on `score_out`.
- `busy`, out, 1: a pass is in progress.
- `done`, out, 1: one-cycle pulse when the results become valid.
- `best_class`, out, `CW`: index of the winning class.
- `best_score`, out, `SW`: score of the winning class.
- `score_out`, out, `SW`: `acc[class_sel]`. Forced to 0 when `class_sel >= CLASSES`.

## Operation
- Registers: `acc[CLASSES]` (each `SW` bits), step counter, argmax index, running best pair, state.
- **IDLE**
  - `start` = 1: clear all `acc`, set step = 0, go to ACCUM.
  - `start` = 0: hold all state.
- **ACCUM**
  - Each cycle, for every class c in parallel: `acc[c] += popcount(y[c*GROUP + step*CHUNK +: CHUNK])`.
  - On `step == STEPS-1`: go to ARGMAX with idx = 0. Otherwise increment step.
- **ARGMAX**
  - One class compared per cycle.
  - idx = 0: load the best pair with (0, `acc[0]`) unconditionally.
  - idx > 0: replace the best pair only if `acc[idx] > best` (strictly greater). Ties therefore resolve to the lowest index.
  - On `idx == CLASSES-1`: register `best_class`/`best_score`, pulse `done`, return to IDLE.
- Arithmetic is unsigned. `acc` never overflows because its maximum value is `GROUP`, which fits in `SW` bits.
- `busy` = (state != IDLE), registered.
- `start` while busy is ignored and has no side effect.
- `best_class`, `best_score` and all `acc` hold their values after `done` until the next accepted `start`. `acc` clears on that `start` edge; the best outputs keep their old values until the next `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `best_class`=0, `best_score`=0, all `acc`=0 (so `score_out`=0), state IDLE.
- Reset asserted mid-pass aborts the pass immediately. No `done` pulse follows it.
- Latency: `start` sampled at edge E0.
  - `busy` is high after E0.
  - Last accumulation happens at edge E(STEPS).
  - `done`=1 and the results are valid after edge E(STEPS+CLASSES).
  - `busy` falls at that same edge.
  - Defaults: 20 cycles.
- `done` is high for exactly one cycle, which is an IDLE cycle. A `start` in that cycle is accepted (back-to-back passes). Throughput: one pass per `STEPS+CLASSES` cycles.
- `score_out` is a combinational mux of registered `acc`. Mid-pass it shows partial sums; it is exact once `done` has pulsed.
- `y` is sampled chunk by chunk during ACCUM. If `y` changes mid-pass, each chunk takes the value present on its own accumulation edge; there is no error flag.

## Test plan
All scenarios use default parameters.
- **All zeros.** `y` = 0, pulse `start` → `done` 20 cycles later; `best_class`=0, `best_score`=0; `score_out`=0 for every `class_sel` 0..9.
- **All ones.** `y` all ones → every `acc`=400; tie gives `best_class`=0, `best_score`=400; `class_sel`=12 gives `score_out`=0.
- **Dominant class, spread across chunks.** Class 7 has 123 ones spread over all 10 chunks, class 3 has 122, the rest have 5 → `best_class`=7, `best_score`=123; `score_out` with `class_sel`=3 reads 122.
- **Late tie.** Classes 2 and 9 have 50 each, the rest 10 → `best_class`=2.
- **Start while busy, then back-to-back.** Pulse `start` again at cycles 5 and 15 of a pass → single `done` at cycle 20. Assert `start` in the `done` cycle → second `done` exactly 20 cycles later with correct results for the new `y`.
- **Reset mid-pass.** Drop `rst_n` at cycle 12 → `busy`/`done`/`best_*`/`acc` go to 0 asynchronously; no `done` pulse afterwards. A new `start` after reset release completes normally.
